lighthouse_pulse_gen: RTL

- Synthetic Lighthouse‑v1 light transmitter. Generates the envelope/data waveforms that NUMBER_OF_SENSOR TS4231 front ends emit in WATCH state: a common sync pulse per frame, then a per‑sensor sweep pulse at a programmable delay.
- Drives the D/E inputs of the ts4231 receiver in loopback and hardware‑in‑the‑loop builds, with no base station present.

---
 rtl/lighthouse_pulse_gen.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/lighthouse_pulse_gen.sv
// lighthouse_pulse_gen -- synthetic Lighthouse-v1 transmitter for loopback/HIL.
// Emits, per frame, a common sync pulse whose width encodes {skip,data,axis},
// then a per-sensor sweep pulse at a programmable delay, on the D/E pins that
// NUMBER_OF_SENSOR TS4231 front ends would drive in WATCH state.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   enable              run request, sampled only at frame boundaries
//   cfg_valid/cfg_ready config handshake into a one-deep pending slot
//   cfg_delay           per-sensor sweep delay, sensor i at [i*DW +: DW]
//   cfg_data, cfg_skip  OOTX data bit / sync-only frame
//   e_n, d_o            envelope (active low) and data (= ~e_n) per sensor
//   frame_start         one-cycle strobe on fc==0
//   axis_o              axis bit of the current frame
//   busy                high while running
//
// Optional: define LH_PULSE_GEN_JITTER_EN to add a per-frame LFSR jitter
// (0..7 cycles) to every sweep delay.

// Per-sensor sweep window decode. Purely combinational; evaluated against the
// next-cycle frame count so the registered e_n lines up with fc.
module lighthouse_pulse_lane #(
  parameter int DW          = 19,
  parameter int FRAME_TICKS = 400000,
  parameter int SWEEP_WIDTH = 480,
  parameter int SWEEP_MIN   = 6980
) (
  input  logic [DW-1:0] delay,
  input  logic [2:0]    jit,
  input  logic [DW-1:0] fc,
  input  logic          skip,
  output logic          hit
);
  localparam logic [DW:0] SW_W  = (DW+1)'(SWEEP_WIDTH);
  localparam logic [DW:0] FT_W  = (DW+1)'(FRAME_TICKS);
  localparam logic [DW:0] MIN_W = (DW+1)'(SWEEP_MIN);

  logic [DW:0] d_j, d_end, fc_w;
  logic        valid;

  // One extra bit keeps D+J+SWEEP_WIDTH from wrapping.
  assign d_j   = {1'b0, delay} + {{(DW-2){1'b0}}, jit};
  assign d_end = d_j + SW_W;
  assign fc_w  = {1'b0, fc};
  // Invalid delays are dropped whole: never clipped, never on top of sync.
  assign valid = (d_j >= MIN_W) && (d_end <= FT_W);
  assign hit   = ~skip & valid & (fc_w >= d_j) & (fc_w < d_end);
endmodule

module lighthouse_pulse_gen #(
  parameter int NUMBER_OF_SENSOR = 2,
  parameter int FRAME_TICKS      = 400000,
  parameter int SYNC_BASE        = 3000,
  parameter int SYNC_STEP        = 500,
  parameter int SWEEP_WIDTH      = 480,
  parameter int DW               = 19
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [NUMBER_OF_SENSOR*DW-1:0] cfg_delay,
  input  logic                         cfg_data,
  input  logic                         cfg_skip,
  output logic [NUMBER_OF_SENSOR-1:0]  e_n,
  output logic [NUMBER_OF_SENSOR-1:0]  d_o,
  output logic                         frame_start,
  output logic                         axis_o,
  output logic                         busy
);
  localparam int N = NUMBER_OF_SENSOR;
  localparam logic [DW-1:0] FC_LAST = DW'(FRAME_TICKS - 1);
  localparam logic [DW:0]   SB_W    = (DW+1)'(SYNC_BASE);
  localparam logic [DW:0]   ST_W    = (DW+1)'(SYNC_STEP);
  localparam int SWEEP_MIN = SYNC_BASE + 7*SYNC_STEP + SWEEP_WIDTH;

  typedef struct packed {
    logic [N*DW-1:0] delay;
    logic            data;
    logic            skip;
  } cfg_t;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_nx;
  logic [DW-1:0]   fc, fc_nx;
  logic            axis_nx, wrap, start, xfer;
  cfg_t            pend, pend_nx, act, act_nx, cfg_in;
  logic            pend_full, pend_full_nx;
  logic [2:0]      code, jit;
  logic [DW:0]     sync_w;
  logic            sync_hit;
  logic [N-1:0]    sweep_hit, e_n_nx;

  assign cfg_in    = '{delay: cfg_delay, data: cfg_data, skip: cfg_skip};
  assign cfg_ready = ~pend_full;
  assign xfer      = cfg_valid & ~pend_full;
  assign busy      = (state == RUN);
  assign d_o       = ~e_n;

`ifdef LH_PULSE_GEN_JITTER_EN
  logic [15:0] lfsr, lfsr_nx;
  logic        lfsr_fb;
  // Fibonacci taps 16,14,13,11; advanced once per frame start.
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign lfsr_nx = start ? {lfsr[14:0], lfsr_fb} : lfsr;
  assign jit     = lfsr_nx[2:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr <= 16'hACE1;
    else     lfsr <= lfsr_nx;
`else
  assign jit = 3'd0;
`endif

  // Next-state/next-output logic. Everything is computed for the cycle after
  // the edge, so the registered e_n always matches the registered fc.
  always_comb begin
    state_nx     = state;
    axis_nx      = axis_o;
    wrap         = (state == RUN) && (fc == FC_LAST);
    start        = enable && ((state == IDLE) || wrap);
    fc_nx        = (state == RUN && !wrap) ? fc + DW'(1) : '0;
    case (state)
      IDLE: if (enable) begin
        state_nx = RUN;
        axis_nx  = 1'b0;             // first frame after IDLE is axis 0
      end
      RUN: if (wrap) begin
        if (enable) axis_nx = ~axis_o;
        else begin
          state_nx = IDLE;
          axis_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    // Old pending moves to active before a coincident capture overwrites it.
    act_nx       = (start && pend_full) ? pend : act;
    pend_nx      = xfer ? cfg_in : pend;
    pend_full_nx = xfer ? 1'b1 : (start ? 1'b0 : pend_full);
    code         = {act_nx.skip, act_nx.data, axis_nx};
    sync_w       = SB_W + ST_W * {{(DW-2){1'b0}}, code};
    sync_hit     = ({1'b0, fc_nx} < sync_w);
    e_n_nx       = (state_nx == RUN) ? ~({N{sync_hit}} | sweep_hit) : '1;
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    lighthouse_pulse_lane #(
      .DW(DW), .FRAME_TICKS(FRAME_TICKS),
      .SWEEP_WIDTH(SWEEP_WIDTH), .SWEEP_MIN(SWEEP_MIN)
    ) u_lane (
      .delay (act_nx.delay[i*DW +: DW]),
      .jit   (jit),
      .fc    (fc_nx),
      .skip  (act_nx.skip),
      .hit   (sweep_hit[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      fc          <= '0;
      e_n         <= '1;
      frame_start <= 1'b0;
      axis_o      <= 1'b1;
      pend        <= '0;
      pend_full   <= 1'b0;
      act         <= '0;
    end else begin
      state       <= state_nx;
      fc          <= fc_nx;
      e_n         <= e_n_nx;
      frame_start <= start;
      axis_o      <= axis_nx;
      pend        <= pend_nx;
      pend_full   <= pend_full_nx;
      act         <= act_nx;
    end
  end
endmodule
